multi_channel_divider: RTL and testbench
========================================

MULTI_CHANNEL_DIVIDER -- requirements
Module: multi_channel_divider

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NUM_CH  4  number of independent divider channels (1..16)
  CNT_W  27  counter/period width in bits
  DEFAULT_PERIOD  50_000_000  period loaded at reset (1 Hz toggle from 100 MHz)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  i_clk  in  1  system clock
  reset_n  in  1  asynchronous active-low reset
  i_cfg_valid  in  1  config write request
  o_cfg_ready  out  1  config write accepted when high with i_cfg_valid
  i_cfg_ch  in  max(1,$clog2(NUM_CH))  target channel
  i_cfg_period  in  CNT_W  period P in i_clk cycles
  i_cfg_high  in  CNT_W  high time H for PWM/ONESHOT
  i_cfg_mode  in  2  channel mode
  i_ch_en  in  NUM_CH  per-channel run enable
  o_clk_out  out  NUM_CH  divided/PWM output per channel
  o_tick  out  NUM_CH  one-cycle pulse per period per channel

Function
REQ-003 Each channel SHALL own a CNT_W counter counting 0..P-1 and wrapping to 0; P=0 SHALL be treated as P=1.
REQ-004 o_tick[c] SHALL be registered, high for exactly one cycle, the cycle after cnt==P-1; consecutive ticks exactly P cycles apart.
REQ-005 Mode 00 TOGGLE: o_clk_out[c] SHALL toggle on each wrap, giving output period 2P cycles.
REQ-006 Mode 01 PWM: o_clk_out[c] SHALL be registered (cnt<H); H=0 gives constant 0; H>=P gives constant 1.
REQ-007 Mode 10 ONESHOT: after enable rises, channel SHALL run one period (o_clk_out high while cnt<H), emit one o_tick, then hold cnt=0, outputs 0, until i_ch_en falls and rises again.
REQ-008 Mode 11 SHALL behave as TOGGLE.
REQ-009 i_ch_en[c] low SHALL hold cnt at 0, o_tick[c]=0, o_clk_out[c]=0 from the next edge; re-enable SHALL restart from cnt=0, first o_tick P cycles after the first edge with enable high.
REQ-010 Accepted writes SHALL go to a per-channel shadow register and set pending[c]; o_cfg_ready SHALL equal ~pending[i_cfg_ch] (combinational).
REQ-011 Shadow SHALL be copied to active config at the first wrap strictly after acceptance, or on the next edge if the channel is disabled; pending[c] SHALL clear on that copy.
REQ-012 Write accepted in the same cycle the channel wraps SHALL apply at the following wrap, never mid-period.
REQ-013 Writes with i_cfg_ch >= NUM_CH SHALL be accepted (ready=1) and discarded.
REQ-014 Mode change SHALL clear the TOGGLE output state to 0 when applied.

Reset
REQ-015 reset_n low SHALL asynchronously clear: all counters 0, o_tick 0, o_clk_out 0, pending 0, ONESHOT done flags 0.
REQ-016 On reset, active and shadow config SHALL be P=DEFAULT_PERIOD, H=DEFAULT_PERIOD/2, mode TOGGLE.
REQ-017 Reset asserted mid-period or with a pending write SHALL discard the write; release SHALL be synchronised to i_clk by the instantiating top.

Structure
REQ-018 Package mcd_pkg SHALL hold the mode enum (TOGGLE, PWM, ONESHOT, RSVD) and default period/high constants.
REQ-019 Per-channel logic SHALL be one sub-module divider_channel, generated NUM_CH times; top holds only config decode and ready mux.

Verification (NUM_CH=2, CNT_W=8, DEFAULT_PERIOD=5)
REQ-020 Reset release, ch0 enabled, no writes -> o_tick[0] every 5 cycles, o_clk_out[0] period 10 cycles, 50% duty.
REQ-021 Write ch1 P=8 H=3 mode PWM, enable -> o_clk_out[1] high 3 of every 8 cycles; H=0 -> constant 0; H=9 -> constant 1.
REQ-022 Write ch0 P=3 mid-period -> o_cfg_ready low for ch0 until current 5-cycle period ends, then ticks 3 apart; second write while pending stalls.
REQ-023 ONESHOT P=4 H=2 -> one 2-cycle high pulse, one o_tick, then idle; disable/enable retriggers exactly once.
REQ-024 Assert reset_n mid-period with pending write -> all outputs 0 immediately, post-reset period is 5, write lost; i_cfg_ch=3 write accepted, no channel changes.

Source files
------------

// File: rtl/mcd_pkg.sv
// Shared types and reset constants for the multi-channel clock/PWM divider.
package mcd_pkg;

  typedef enum logic [1:0] {
    TOGGLE  = 2'b00,
    PWM     = 2'b01,
    ONESHOT = 2'b10,
    RSVD    = 2'b11
  } mode_e;

  localparam int MCD_DEFAULT_PERIOD = 50_000_000;
  localparam int MCD_DEFAULT_HIGH   = MCD_DEFAULT_PERIOD / 2;

  function automatic int default_high(input int period);
    return period / 2;
  endfunction

  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/divider_channel.sv
// One divider channel: free-running period counter, tick/toggle/PWM/one-shot
// output, and a shadow config that is only applied on a period boundary.
module divider_channel
  import mcd_pkg::*;
#(
  parameter int CNT_W          = 27,
  parameter int DEFAULT_PERIOD = MCD_DEFAULT_PERIOD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  mode_e            cfg_mode,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] RST_HIGH   = CNT_W'(default_high(DEFAULT_PERIOD));

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] period_reg;
  logic [CNT_W-1:0] high_reg;
  logic [CNT_W-1:0] sh_period_reg;
  logic [CNT_W-1:0] sh_high_reg;
  mode_e            mode_reg;
  mode_e            sh_mode_reg;
  logic             pending_reg;
  logic             run_reg;
  logic             done_reg;
  logic             clk_out_reg;
  logic             tick_reg;

  logic [CNT_W-1:0] last_cnt;
  logic             counting;
  logic             wrap;
  logic             apply;
  logic             accept;
  logic             is_toggle;

  // run_reg delays counting by one edge so a fresh enable starts a full period at cnt=0.
  always_comb begin
    last_cnt  = (period_reg == '0) ? '0 : period_reg - CNT_W'(1);
    counting  = en & run_reg & ~done_reg;
    wrap      = counting & (cnt_reg >= last_cnt);
    apply     = pending_reg & (wrap | ~counting);
    accept    = cfg_wr & ~pending_reg;
    is_toggle = (mode_reg == TOGGLE) || (mode_reg == RSVD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      run_reg     <= 1'b0;
      done_reg    <= 1'b0;
      clk_out_reg <= 1'b0;
      tick_reg    <= 1'b0;
    end else begin
      run_reg <= en;
      if (!counting) begin
        cnt_reg     <= '0;
        tick_reg    <= 1'b0;
        clk_out_reg <= 1'b0;
        if (!en) begin
          done_reg <= 1'b0;
        end
      end else begin
        cnt_reg  <= wrap ? '0 : cnt_reg + CNT_W'(1);
        tick_reg <= wrap;
        if (wrap && (mode_reg == ONESHOT)) begin
          done_reg <= 1'b1;
        end
        if (apply && (sh_mode_reg != mode_reg)) begin
          clk_out_reg <= 1'b0;
        end else if (is_toggle) begin
          clk_out_reg <= clk_out_reg ^ wrap;
        end else begin
          clk_out_reg <= (cnt_reg < high_reg);
        end
      end
    end
  end

  // A write seen as pending only from the next edge, so a wrap in the accept cycle never applies it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_reg    <= RST_PERIOD;
      high_reg      <= RST_HIGH;
      mode_reg      <= TOGGLE;
      sh_period_reg <= RST_PERIOD;
      sh_high_reg   <= RST_HIGH;
      sh_mode_reg   <= TOGGLE;
      pending_reg   <= 1'b0;
    end else if (apply) begin
      period_reg  <= sh_period_reg;
      high_reg    <= sh_high_reg;
      mode_reg    <= sh_mode_reg;
      pending_reg <= 1'b0;
    end else if (accept) begin
      sh_period_reg <= cfg_period;
      sh_high_reg   <= cfg_high;
      sh_mode_reg   <= cfg_mode;
      pending_reg   <= 1'b1;
    end
  end

  assign pending = pending_reg;
  assign clk_out = clk_out_reg;
  assign tick    = tick_reg;

endmodule

// File: rtl/multi_channel_divider.sv
// Multi-channel divider top: config channel decode, ready mux and the
// generated array of divider channels.
module multi_channel_divider
  import mcd_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 27,
  parameter int DEFAULT_PERIOD = MCD_DEFAULT_PERIOD,
  localparam int CH_W          = ch_idx_w(NUM_CH)
) (
  input  logic              i_clk,
  input  logic              reset_n,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [CNT_W-1:0]  i_cfg_period,
  input  logic [CNT_W-1:0]  i_cfg_high,
  input  logic [1:0]        i_cfg_mode,
  input  logic [NUM_CH-1:0] i_ch_en,
  output logic [NUM_CH-1:0] o_clk_out,
  output logic [NUM_CH-1:0] o_tick
);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] cfg_sel;

  // Out-of-range channel indices match no channel: ready stays high and the write is dropped.
  always_comb begin
    cfg_sel     = '0;
    o_cfg_ready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (i_cfg_ch == CH_W'(c)) begin
        cfg_sel[c]  = 1'b1;
        o_cfg_ready = ~pending[c];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      divider_channel #(
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
      ) u_ch (
        .clk        (i_clk),
        .rst_n      (reset_n),
        .en         (i_ch_en[gi]),
        .cfg_wr     (i_cfg_valid & cfg_sel[gi]),
        .cfg_period (i_cfg_period),
        .cfg_high   (i_cfg_high),
        .cfg_mode   (mode_e'(i_cfg_mode)),
        .pending    (pending[gi]),
        .clk_out    (o_clk_out[gi]),
        .tick       (o_tick[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_channel_divider.sv
// Directed bench for multi_channel_divider with a tick-time scoreboard.
module tb_multi_channel_divider;

  // Three channels so that channel index 3 is representable and out of range.
  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int HIST_N = 4096;

  logic             i_clk = 1'b0;
  logic             reset_n;
  logic             i_cfg_valid;
  logic             o_cfg_ready;
  logic [1:0]       i_cfg_ch;
  logic [CNT_W-1:0] i_cfg_period;
  logic [CNT_W-1:0] i_cfg_high;
  logic [1:0]       i_cfg_mode;
  logic [2:0]       i_ch_en;
  logic [2:0]       o_clk_out;
  logic [2:0]       o_tick;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int cur;
  int q0[$];
  int q1[$];
  logic [2:0] hist [0:HIST_N-1];

  multi_channel_divider #(
    .NUM_CH         (NUM_CH),
    .CNT_W          (CNT_W),
    .DEFAULT_PERIOD (5)
  ) dut (
    .i_clk        (i_clk),
    .reset_n      (reset_n),
    .i_cfg_valid  (i_cfg_valid),
    .o_cfg_ready  (o_cfg_ready),
    .i_cfg_ch     (i_cfg_ch),
    .i_cfg_period (i_cfg_period),
    .i_cfg_high   (i_cfg_high),
    .i_cfg_mode   (i_cfg_mode),
    .i_ch_en      (i_ch_en),
    .o_clk_out    (o_clk_out),
    .o_tick       (o_tick)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n cycles; every observed tick pops the expected cycle for its channel.
  task automatic watch(input int n);
    int e;
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk);
      if (cyc < HIST_N) hist[cyc] = o_clk_out;
      if (o_tick[0]) begin
        e = (q0.size() > 0) ? q0.pop_front() : -1;
        check("tick_ch0_cycle", cyc, e);
      end
      if (o_tick[1]) begin
        e = (q1.size() > 0) ? q1.pop_front() : -1;
        check("tick_ch1_cycle", cyc, e);
      end
      if (o_tick[2]) check("tick_ch2_unexpected", 1, 0);
    end
  endtask

  function automatic logic exp_toggle(input int k, input int p);
    if (k < p + 1) return 1'b0;
    return (((k - p - 1) / p) % 2) == 0;
  endfunction

  // Write to a disabled channel: accepted, pending for one cycle, then applied.
  task automatic cfg_write(input int ch, input int p, input int h, input int m);
    i_cfg_valid = 1'b1; i_cfg_ch = 2'(ch);
    i_cfg_period = 8'(p); i_cfg_high = 8'(h); i_cfg_mode = 2'(m);
    check("wr_ready_before", o_cfg_ready, 1);
    watch(1);
    i_cfg_valid = 1'b0;
    check("wr_pending", o_cfg_ready, 0);
    watch(1);
    check("wr_applied_idle", o_cfg_ready, 1);
  endtask

  task automatic pwm_run(input int h);
    logic e;
    cfg_write(1, 8, h, 1);
    i_ch_en = 3'b010;
    cur = cyc;
    q1.push_back(cur + 9);
    q1.push_back(cur + 17);
    watch(20);
    for (int k = 1; k <= 20; k++) begin
      if (h == 0)      e = 1'b0;
      else if (h >= 8) e = (k >= 2);
      else             e = (k >= 2) && (((k - 2) % 8) < h);
      check($sformatf("pwm_h%0d_clk1_k%0d", h, k), hist[cur + k][1], e);
    end
    check("pwm_q1_drained", q1.size(), 0);
    i_ch_en = 3'b000;
    watch(1);
    check("pwm_disable_clk1", o_clk_out[1], 0);
  endtask

  initial begin
    reset_n = 1'b1; i_cfg_valid = 1'b0; i_cfg_ch = '0;
    i_cfg_period = '0; i_cfg_high = '0; i_cfg_mode = '0; i_ch_en = 3'b000;
    #2 reset_n = 1'b0;
    watch(3);
    check("rst_tick", o_tick, 0);
    check("rst_clk_out", o_clk_out, 0);
    check("rst_ready", o_cfg_ready, 1);

    // Default toggle on ch0: ticks every 5, output period 10.
    reset_n = 1'b1; i_ch_en = 3'b001; cur = cyc;
    q0.push_back(cur + 6); q0.push_back(cur + 11); q0.push_back(cur + 16);
    watch(18);
    for (int k = 1; k <= 18; k++)
      check($sformatf("dflt_clk0_k%0d", k), hist[cur + k][0], exp_toggle(k, 5));
    check("dflt_q0_drained", q0.size(), 0);
    i_ch_en = 3'b000;
    watch(1);
    check("dis_clk0", o_clk_out[0], 0);
    check("dis_tick0", o_tick[0], 0);
    watch(8);

    // PWM on ch1: nominal, H=0, H>P.
    pwm_run(3);
    pwm_run(0);
    pwm_run(9);

    // Mid-period write to ch0, then a second write that stalls while pending.
    i_ch_en = 3'b001; cur = cyc;
    q0.push_back(cur + 6);  q0.push_back(cur + 11); q0.push_back(cur + 16);
    q0.push_back(cur + 19); q0.push_back(cur + 23); q0.push_back(cur + 27);
    watch(13);
    i_cfg_valid = 1'b1; i_cfg_ch = 2'd0;
    i_cfg_period = 8'd3; i_cfg_high = 8'd1; i_cfg_mode = 2'd0;
    check("mid_ready_free", o_cfg_ready, 1);
    watch(1);
    i_cfg_period = 8'd4;
    check("mid_stall_a", o_cfg_ready, 0);
    watch(1);
    check("mid_stall_b", o_cfg_ready, 0);
    watch(1);
    check("mid_ready_after_wrap", o_cfg_ready, 1);
    watch(1);
    i_cfg_valid = 1'b0;
    check("mid_second_pending", o_cfg_ready, 0);
    watch(11);
    check("mid_q0_drained", q0.size(), 0);
    check("mid_second_applied", o_cfg_ready, 1);
    i_ch_en = 3'b000;
    watch(2);

    // One-shot on ch1, then retrigger via disable/enable.
    cfg_write(1, 4, 2, 2);
    for (int r = 0; r < 2; r++) begin
      i_ch_en = 3'b010; cur = cyc;
      q1.push_back(cur + 5);
      watch(12);
      for (int k = 1; k <= 12; k++)
        check($sformatf("os%0d_clk1_k%0d", r, k), hist[cur + k][1], (k == 2) || (k == 3));
      check($sformatf("os%0d_q1_drained", r), q1.size(), 0);
      i_ch_en = 3'b000;
      watch(2);
    end

    // Reset during a period with a pending write on ch0 (ch0 now P=4).
    i_ch_en = 3'b001; cur = cyc;
    q0.push_back(cur + 5);
    watch(7);
    i_cfg_valid = 1'b1; i_cfg_ch = 2'd0;
    i_cfg_period = 8'd3; i_cfg_high = 8'd1; i_cfg_mode = 2'd0;
    check("pre_rst_ready", o_cfg_ready, 1);
    watch(1);
    i_cfg_valid = 1'b0;
    check("pre_rst_pending", o_cfg_ready, 0);
    check("pre_rst_clk0", o_clk_out[0], 1);
    check("pre_rst_q0_drained", q0.size(), 0);
    reset_n = 1'b0;
    #1;
    check("async_rst_tick", o_tick, 0);
    check("async_rst_clk_out", o_clk_out, 0);
    check("async_rst_ready", o_cfg_ready, 1);
    watch(2);
    reset_n = 1'b1; cur = cyc;
    q0.push_back(cur + 6); q0.push_back(cur + 11);
    q0.push_back(cur + 16); q0.push_back(cur + 21);
    watch(2);
    i_cfg_valid = 1'b1; i_cfg_ch = 2'd3;
    i_cfg_period = 8'd3; i_cfg_high = 8'd1; i_cfg_mode = 2'd1;
    check("oor_ready", o_cfg_ready, 1);
    watch(1);
    i_cfg_valid = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      i_cfg_ch = 2'(c);
      #1 check($sformatf("oor_no_pending_ch%0d", c), o_cfg_ready, 1);
    end
    i_cfg_ch = 2'd0;
    watch(20);
    for (int k = 1; k <= 23; k++)
      check($sformatf("post_rst_clk0_k%0d", k), hist[cur + k][0], exp_toggle(k, 5));
    check("post_rst_q0_drained", q0.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
